// File: rtl/board_writer.sv
// Write side of the 16x16 five-in-a-row board: validates and commits stones, sequences the checker chain,
// and tracks turn/moves/winner. Optional single-level undo is enabled with `define BOARD_WRITER_UNDO_EN.
module board_writer #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         MAX_MOVES    = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         place_req,
    input  logic [7:0]   pointer,
    input  logic [1:0]   chess,
    input  logic         clear_req,
`ifdef BOARD_WRITER_UNDO_EN
    input  logic         undo_req,
`endif
    input  logic         chk_success,
    input  logic         chk_fail,
    output logic [511:0] board,
    output logic         chk_reset,
    output logic         chk_active,
    output logic [7:0]   chk_pointer,
    output logic [1:0]   chk_chess,
    output logic         accepted,
    output logic         rejected,
    output logic         done,
    output logic         busy,
    output logic [1:0]   turn,
    output logic         game_over,
    output logic [1:0]   winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_CHECK,
        S_OVER
    } state_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_MOVES);

    state_t       r_state;
    logic [511:0] r_board;
    logic [3:0]   r_row;
    logic [8:0]   r_move_count;
    logic [1:0]   r_turn;
    logic [1:0]   r_winner;
    logic         r_game_over;
    logic         r_busy;
    logic         r_chk_reset;
    logic         r_chk_active;
    logic [7:0]   r_chk_pointer;
    logic [1:0]   r_chk_chess;
    logic         r_accepted;
    logic         r_rejected;
    logic         r_done;
`ifdef BOARD_WRITER_UNDO_EN
    logic [7:0]   r_last_ptr;
    logic         r_undo_valid;
`endif

    logic [1:0]   w_cell;
    logic         w_code_ok;
    logic         w_legal;
    logic [1:0]   w_turn_next;

    // A placement is legal only for a real stone, of the side to move, onto an empty cell.
    assign w_cell      = r_board[{pointer, 1'b0} +: 2];
    assign w_code_ok   = (chess == 2'b01) || (chess == 2'b10);
    assign w_legal     = w_code_ok && (chess == r_turn) && (w_cell == 2'b00);
    assign w_turn_next = (r_turn == 2'b01) ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_board       <= '0;
            r_row         <= '0;
            r_move_count  <= '0;
            r_turn        <= FIRST_PLAYER;
            r_winner      <= 2'b00;
            r_game_over   <= 1'b0;
            r_busy        <= 1'b0;
            r_chk_reset   <= 1'b0;
            r_chk_active  <= 1'b0;
            r_chk_pointer <= '0;
            r_chk_chess   <= 2'b00;
            r_accepted    <= 1'b0;
            r_rejected    <= 1'b0;
            r_done        <= 1'b0;
`ifdef BOARD_WRITER_UNDO_EN
            r_last_ptr    <= '0;
            r_undo_valid  <= 1'b0;
`endif
        end else begin
            r_accepted <= 1'b0;
            r_rejected <= 1'b0;
            r_done     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end else if (place_req) begin
                        if (w_legal) begin
                            r_board[{pointer, 1'b0} +: 2] <= chess;
                            r_chk_pointer <= pointer;
                            r_chk_chess   <= chess;
                            r_move_count  <= r_move_count + 9'd1;
                            r_accepted    <= 1'b1;
                            r_chk_reset   <= 1'b1;
                            r_chk_active  <= 1'b0;
                            r_busy        <= 1'b1;
                            r_state       <= S_ARM;
`ifdef BOARD_WRITER_UNDO_EN
                            r_last_ptr    <= pointer;
                            r_undo_valid  <= 1'b1;
`endif
                        end else begin
                            r_rejected <= 1'b1;
                        end
`ifdef BOARD_WRITER_UNDO_EN
                    end else if (undo_req) begin
                        if (r_undo_valid && (r_move_count != 9'd0)) begin
                            r_board[{r_last_ptr, 1'b0} +: 2] <= 2'b00;
                            r_move_count <= r_move_count - 9'd1;
                            r_turn       <= w_turn_next;
                            r_undo_valid <= 1'b0;
                            r_accepted   <= 1'b1;
                        end else begin
                            r_rejected <= 1'b1;
                        end
`endif
                    end
                end

                S_ARM: begin
                    r_chk_reset  <= 1'b0;
                    r_chk_active <= 1'b1;
                    r_state      <= S_CHECK;
                end

                // Success outranks fail when both arrive in the same cycle.
                S_CHECK: begin
                    if (chk_success) begin
                        r_winner     <= r_chk_chess;
                        r_chk_active <= 1'b0;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_game_over  <= 1'b1;
                        r_state      <= S_OVER;
                    end else if (chk_fail) begin
                        r_chk_active <= 1'b0;
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        if (r_move_count == MAX_CNT) begin
                            r_winner    <= 2'b00;
                            r_game_over <= 1'b1;
                            r_state     <= S_OVER;
                        end else begin
                            r_turn  <= w_turn_next;
                            r_state <= S_IDLE;
                        end
                    end
                end

                // One 32-bit row per cycle; the exit is taken on row 15 so the counter never wraps.
                S_CLEAR: begin
                    r_board[{r_row, 5'b00000} +: 32] <= '0;
                    if (r_row == 4'd15) begin
                        r_turn       <= FIRST_PLAYER;
                        r_move_count <= '0;
                        r_winner     <= 2'b00;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_row <= r_row + 4'd1;
                    end
                end

                S_OVER: begin
                    if (clear_req) begin
                        r_row       <= '0;
                        r_busy      <= 1'b1;
                        r_game_over <= 1'b0;
                        r_state     <= S_CLEAR;
                    end else if (place_req) begin
                        r_rejected <= 1'b1;
`ifdef BOARD_WRITER_UNDO_EN
                    end else if (undo_req) begin
                        r_rejected <= 1'b1;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign board       = r_board;
    assign chk_reset   = r_chk_reset;
    assign chk_active  = r_chk_active;
    assign chk_pointer = r_chk_pointer;
    assign chk_chess   = r_chk_chess;
    assign accepted    = r_accepted;
    assign rejected    = r_rejected;
    assign done        = r_done;
    assign busy        = r_busy;
    assign turn        = r_turn;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: stimulus pushes expected pulse records, a negedge monitor pops and compares.
module tb_board_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, place_req, clear_req, chk_success, chk_fail;
    logic [7:0]   pointer;
    logic [1:0]   chess;
`ifdef BOARD_WRITER_UNDO_EN
    logic         undo_req;
`endif
    logic [511:0] board;
    logic         chk_reset, chk_active, accepted, rejected, done, busy, game_over;
    logic [7:0]   chk_pointer;
    logic [1:0]   chk_chess, turn, winner;

    board_writer dut (
        .clk(clk), .reset(reset), .place_req(place_req), .pointer(pointer), .chess(chess),
        .clear_req(clear_req),
`ifdef BOARD_WRITER_UNDO_EN
        .undo_req(undo_req),
`endif
        .chk_success(chk_success), .chk_fail(chk_fail), .board(board),
        .chk_reset(chk_reset), .chk_active(chk_active), .chk_pointer(chk_pointer),
        .chk_chess(chk_chess), .accepted(accepted), .rejected(rejected), .done(done),
        .busy(busy), .turn(turn), .game_over(game_over), .winner(winner)
    );

    localparam int K_ACC = 0, K_REJ = 1, K_DONE = 2;

    typedef struct {
        int         kind;
        logic [1:0] turn;
        logic [1:0] winner;
        logic       over;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        int   k;
        int   npulse;
        exp_t e;
        npulse = int'(accepted) + int'(rejected) + int'(done);
        if (npulse != 0) begin
            k = (npulse > 1) ? 3 : (accepted ? K_ACC : (rejected ? K_REJ : K_DONE));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse actual kind=%0d required none", k);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", k, e.kind);
                check("pulse_turn", turn, e.turn);
                check("pulse_winner", winner, e.winner);
                check("pulse_game_over", game_over, e.over);
            end
        end
    end

    task automatic req_place(input logic [7:0] p, input logic [1:0] c, input int k,
                             input logic [1:0] et, input logic [1:0] ew, input logic eo);
        @(negedge clk);
        place_req = 1'b1; pointer = p; chess = c;
        sb.push_back('{k, et, ew, eo});
        @(negedge clk);
        place_req = 1'b0;
    endtask

    task automatic verdict(input logic s, input logic f,
                           input logic [1:0] et, input logic [1:0] ew, input logic eo);
        int n = 0;
        while (chk_active !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL chk_active_wait actual=timeout required=chk_active");
        end else begin
            chk_success = s; chk_fail = f;
            sb.push_back('{K_DONE, et, ew, eo});
            @(negedge clk);
            chk_success = 1'b0; chk_fail = 1'b0;
        end
    endtask

    task automatic do_clear(output int cnt);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

`ifdef BOARD_WRITER_UNDO_EN
    task automatic req_undo(input int k, input logic [1:0] et);
        @(negedge clk);
        undo_req = 1'b1;
        sb.push_back('{k, et, 2'b00, 1'b0});
        @(negedge clk);
        undo_req = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [1:0] c, other;
        reset = 1'b0; place_req = 1'b0; clear_req = 1'b0; chk_success = 1'b0; chk_fail = 1'b0;
        pointer = '0; chess = 2'b00;
`ifdef BOARD_WRITER_UNDO_EN
        undo_req = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_board", board, 512'd0);
        check("rst_turn", turn, 2'b01);
        check("rst_winner", winner, 2'b00);
        check("rst_ctrl", {busy, game_over, chk_reset, chk_active, accepted, rejected, done}, 7'd0);
        check("rst_chk_latch", {chk_pointer, chk_chess}, 10'd0);
        reset = 1'b1;

        // First legal move and the checker handshake.
        req_place(8'h77, 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
        check("cell_77", board[239:238], 2'b01);
        check("arm_chk_reset", {chk_reset, chk_active, busy}, 3'b101);
        check("latched_ptr", chk_pointer, 8'h77);
        check("latched_chess", chk_chess, 2'b01);
        @(negedge clk);
        check("check_chk_active", {chk_reset, chk_active}, 2'b01);
        verdict(1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        check("after_fail_busy", busy, 1'b0);
        check("after_fail_turn", turn, 2'b10);

        // Occupied cell and wrong turn.
        req_place(8'h77, 2'b10, K_REJ, 2'b10, 2'b00, 1'b0);
        check("occupied_unchanged", board[239:238], 2'b01);
        req_place(8'h78, 2'b01, K_REJ, 2'b10, 2'b00, 1'b0);
        check("wrong_turn_unchanged", board[241:240], 2'b00);

        // Build a row for player 01 and win on the fifth stone.
        for (int i = 0; i < 5; i++) begin
            req_place(8'h80 + 8'(i), 2'b10, K_ACC, 2'b10, 2'b00, 1'b0);
            verdict(1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
            if (i < 4) begin
                req_place(8'h70 + 8'(i), 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
                verdict(1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
            end
        end
        req_place(8'h74, 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
        verdict(1'b1, 1'b0, 2'b01, 2'b01, 1'b1);
        check("win_game_over", {game_over, busy}, 2'b10);
        req_place(8'h85, 2'b10, K_REJ, 2'b01, 2'b01, 1'b1);
        check("over_place_unchanged", board[267:266], 2'b00);

        // Clear from OVER.
        do_clear(cnt);
        check("clear_busy_cycles", cnt, 16);
        check("clear_board", board, 512'd0);
        check("clear_state", {turn, winner, game_over}, 5'b01_00_0);

        // Simultaneous success and fail: success wins.
        req_place(8'hF0, 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
        check("cell_F0", board[481:480], 2'b01);
        verdict(1'b1, 1'b1, 2'b01, 2'b01, 1'b1);
        check("both_verdict_over", {game_over, busy}, 2'b10);

        // Reset in the middle of a clear.
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (4) @(negedge clk);
        check("midclear_busy", busy, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midclear_rst_board", board, 512'd0);
        check("midclear_rst_ctrl", {busy, game_over, turn, winner}, 6'b0_0_01_00);

        // Illegal stone codes and wrong first player.
        req_place(8'h00, 2'b00, K_REJ, 2'b01, 2'b00, 1'b0);
        req_place(8'h00, 2'b11, K_REJ, 2'b01, 2'b00, 1'b0);
        req_place(8'h00, 2'b10, K_REJ, 2'b01, 2'b00, 1'b0);
        check("illegal_board", board, 512'd0);

        // Fill the whole board: move 256 ends the game as a draw without toggling turn.
        for (int i = 0; i < 256; i++) begin
            c = (i % 2 == 0) ? 2'b01 : 2'b10;
            other = (i % 2 == 0) ? 2'b10 : 2'b01;
            req_place(8'(i), c, K_ACC, c, 2'b00, 1'b0);
            if (i == 255) verdict(1'b0, 1'b1, 2'b10, 2'b00, 1'b1);
            else          verdict(1'b0, 1'b1, other, 2'b00, 1'b0);
        end
        check("draw_over", {game_over, winner, busy}, 4'b1_00_0);
        check("draw_cell_255", board[511:510], 2'b10);
        req_place(8'h10, 2'b10, K_REJ, 2'b10, 2'b00, 1'b1);

`ifdef BOARD_WRITER_UNDO_EN
        do_clear(cnt);
        check("undo_clear_cycles", cnt, 16);
        req_place(8'h00, 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
        verdict(1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        req_undo(K_ACC, 2'b01);
        check("undo_cell0", board[1:0], 2'b00);
        req_undo(K_REJ, 2'b01);
        req_place(8'h00, 2'b01, K_ACC, 2'b01, 2'b00, 1'b0);
        verdict(1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
